// File: rtl/tile_map_ctrl.sv
// Write-port scheduler (host vs. fill engine) and read sequencer for the 80x60 tile-index RAM.
// Optional bounds checking of host writes is enabled with `define TILE_MAP_CTRL_BOUNDS_CHECK_EN.
//
// state | meaning
// IDLE  | host owns the write port; fill_start launches a sweep
// FILL  | fill engine writes one tile per cycle in row-major order
module tile_map_ctrl #(
  parameter int COLS = 80,
  parameter int ROWS = 60,
  parameter int TW   = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          host_req,
  input  logic [6:0]    host_x,
  input  logic [5:0]    host_y,
  input  logic [TW-1:0] host_v,
  output logic          host_ready,
  input  logic          fill_start,
  input  logic [TW-1:0] fill_v,
  output logic          fill_busy,
  output logic          fill_done,
  input  logic          disp_req,
  input  logic [6:0]    disp_x,
  input  logic [5:0]    disp_y,
  output logic [TW-1:0] disp_tile,
  output logic          disp_valid,
  output logic          tm_w,
  output logic [6:0]    tm_write_x,
  output logic [5:0]    tm_write_y,
  output logic [TW-1:0] tm_v,
  output logic          tm_r,
  output logic [6:0]    tm_x,
  output logic [5:0]    tm_y,
  input  logic [TW-1:0] tm_o
`ifdef TILE_MAP_CTRL_BOUNDS_CHECK_EN
  ,
  output logic          oob_err
`endif
);

  typedef enum logic {IDLE, FILL} state_t;

  localparam logic [6:0] X_LAST = 7'(COLS - 1);
  localparam logic [5:0] Y_LAST = 6'(ROWS - 1);

  state_t        state;
  logic [6:0]    cx;
  logic [5:0]    cy;
  logic [TW-1:0] fill_val;
  logic          host_acc;
  logic          fill_last;

  assign host_ready = (state == IDLE) && !fill_start;
  assign host_acc   = host_req && host_ready;
  assign fill_last  = (cx == X_LAST) && (cy == Y_LAST);

  // Read port is a straight pass-through; only the valid strobe is pipelined.
  assign tm_r      = disp_req;
  assign tm_x      = disp_x;
  assign tm_y      = disp_y;
  assign disp_tile = tm_o;

`ifdef TILE_MAP_CTRL_BOUNDS_CHECK_EN
  logic host_oob;
  assign host_oob = (host_x >= 7'(COLS)) || (host_y >= 6'(ROWS));
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cx         <= '0;
      cy         <= '0;
      fill_val   <= '0;
      fill_busy  <= 1'b0;
      fill_done  <= 1'b0;
      disp_valid <= 1'b0;
      tm_w       <= 1'b0;
      tm_write_x <= '0;
      tm_write_y <= '0;
      tm_v       <= '0;
`ifdef TILE_MAP_CTRL_BOUNDS_CHECK_EN
      oob_err    <= 1'b0;
`endif
    end else begin
      disp_valid <= disp_req;
      fill_done  <= 1'b0;
      case (state)
        IDLE: begin
          if (fill_start) begin
            // The (0,0) write goes out in the very first FILL cycle.
            state      <= FILL;
            fill_val   <= fill_v;
            cx         <= '0;
            cy         <= '0;
            fill_busy  <= 1'b1;
            tm_w       <= 1'b1;
            tm_write_x <= '0;
            tm_write_y <= '0;
            tm_v       <= fill_v;
          end else if (host_acc) begin
            tm_write_x <= host_x;
            tm_write_y <= host_y;
            tm_v       <= host_v;
`ifdef TILE_MAP_CTRL_BOUNDS_CHECK_EN
            tm_w       <= !host_oob;
            if (host_oob) oob_err <= 1'b1;
`else
            tm_w       <= 1'b1;
`endif
          end else begin
            tm_w <= 1'b0;
          end
        end
        FILL: begin
          // cx/cy track the tile being written during the current cycle.
          if (fill_last) begin
            state     <= IDLE;
            fill_busy <= 1'b0;
            fill_done <= 1'b1;
            tm_w      <= 1'b0;
          end else begin
            if (cx == X_LAST) begin
              cx         <= '0;
              cy         <= cy + 6'd1;
              tm_write_x <= '0;
              tm_write_y <= cy + 6'd1;
            end else begin
              cx         <= cx + 7'd1;
              tm_write_x <= cx + 7'd1;
              tm_write_y <= cy;
            end
            tm_w <= 1'b1;
            tm_v <= fill_val;
          end
        end
        default: begin
          state     <= IDLE;
          fill_busy <= 1'b0;
          tm_w      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tile_map_ctrl.sv
// Directed bench for tile_map_ctrl with a behavioural 80x60 tile RAM attached.
// Build with or without `define TILE_MAP_CTRL_BOUNDS_CHECK_EN.
module tb_tile_map_ctrl;
  logic       clk = 1'b0;
  logic       rst;
  logic       host_req, host_ready, fill_start, fill_busy, fill_done;
  logic [6:0] host_x, disp_x, tm_write_x, tm_x;
  logic [5:0] host_y, disp_y, tm_write_y, tm_y;
  logic [5:0] host_v, fill_v, disp_tile, tm_v, tm_o;
  logic       disp_req, disp_valid, tm_w, tm_r;
`ifdef TILE_MAP_CTRL_BOUNDS_CHECK_EN
  logic       oob_err;
`endif

  int checks = 0;
  int failures = 0;
  int fidx = 0;
  int fcount = 0;
  int ferr = 0;
  logic [5:0] ram [0:4799];

  tile_map_ctrl #(.COLS(80), .ROWS(60), .TW(6)) dut (
    .clk(clk), .rst(rst),
    .host_req(host_req), .host_x(host_x), .host_y(host_y), .host_v(host_v),
    .host_ready(host_ready),
    .fill_start(fill_start), .fill_v(fill_v), .fill_busy(fill_busy), .fill_done(fill_done),
    .disp_req(disp_req), .disp_x(disp_x), .disp_y(disp_y),
    .disp_tile(disp_tile), .disp_valid(disp_valid),
    .tm_w(tm_w), .tm_write_x(tm_write_x), .tm_write_y(tm_write_y), .tm_v(tm_v),
    .tm_r(tm_r), .tm_x(tm_x), .tm_y(tm_y), .tm_o(tm_o)
`ifdef TILE_MAP_CTRL_BOUNDS_CHECK_EN
    , .oob_err(oob_err)
`endif
  );

  always #5 clk = ~clk;

  // Tile RAM with registered read data.
  always @(posedge clk) begin
    if (tm_w && tm_write_x < 7'd80 && tm_write_y < 6'd60)
      ram[int'(tm_write_y) * 80 + int'(tm_write_x)] <= tm_v;
    if (tm_r && tm_x < 7'd80 && tm_y < 6'd60)
      tm_o <= ram[int'(tm_y) * 80 + int'(tm_x)];
  end

  // Fill sweep order monitor.
  always @(posedge clk) begin
    if (tm_w && fill_busy) begin
      if (tm_write_x !== 7'(fidx % 80) || tm_write_y !== 6'(fidx / 80)) ferr <= ferr + 1;
      fidx   <= fidx + 1;
      fcount <= fcount + 1;
    end else if (!fill_busy) begin
      fidx <= 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [6:0] x, input logic [5:0] y, input logic [5:0] exp, input string tag);
    disp_req = 1'b1; disp_x = x; disp_y = y;
    step();
    chk({tag, "_valid"}, 32'(disp_valid), 32'd1);
    chk(tag, 32'(disp_tile), 32'(exp));
    disp_req = 1'b0;
  endtask

  initial begin
    int cyc;
    int fc0;
    int bad;
    for (int i = 0; i < 4800; i++) ram[i] = 6'h00;
    tm_o = 6'h00;
    rst = 1'b1;
    host_req = 0; host_x = 0; host_y = 0; host_v = 0;
    fill_start = 0; fill_v = 0;
    disp_req = 0; disp_x = 0; disp_y = 0;
    #22;
    chk("rst_tm_w", 32'(tm_w), 0);
    chk("rst_fill_busy", 32'(fill_busy), 0);
    chk("rst_fill_done", 32'(fill_done), 0);
    chk("rst_disp_valid", 32'(disp_valid), 0);
    chk("rst_tm_addr", {tm_write_x, tm_write_y, tm_v}, 0);
`ifdef TILE_MAP_CTRL_BOUNDS_CHECK_EN
    chk("rst_oob_err", 32'(oob_err), 0);
`endif
    step();
    rst = 1'b0;
    #1;
    chk("rst_host_ready", 32'(host_ready), 1);

    // Back-to-back host writes
    host_req = 1; host_x = 5; host_y = 3; host_v = 6'h2A;
    step();
    chk("hw1_tm_w", 32'(tm_w), 1);
    chk("hw1_addr", {tm_write_x, tm_write_y, tm_v}, {7'd5, 6'd3, 6'h2A});
    host_x = 79; host_y = 59; host_v = 6'h3F;
    step();
    chk("hw2_tm_w", 32'(tm_w), 1);
    chk("hw2_addr", {tm_write_x, tm_write_y, tm_v}, {7'd79, 6'd59, 6'h3F});
    host_req = 0;
    step();
    chk("hw_idle_tm_w", 32'(tm_w), 0);
    disp_req = 1; disp_x = 5; disp_y = 3;
    #1;
    chk("rd_passthru", {tm_r, tm_x, tm_y}, {1'b1, 7'd5, 6'd3});
    rd(7'd5, 6'd3, 6'h2A, "rd_5_3");
    rd(7'd79, 6'd59, 6'h3F, "rd_79_59");
    step();
    chk("rd_idle_valid", 32'(disp_valid), 0);

    // Asynchronous reset in the middle of a cycle
    host_req = 1; host_x = 1; host_y = 1; host_v = 6'h07; disp_req = 1;
    step();
    host_req = 0; disp_req = 0;
    chk("pre_rst_tm_w", 32'(tm_w), 1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_tm_w", 32'(tm_w), 0);
    chk("async_rst_disp_valid", 32'(disp_valid), 0);
    chk("async_rst_tm_addr", {tm_write_x, tm_write_y, tm_v}, 0);
    step();
    rst = 1'b0;
    #1;
    chk("async_rst_host_ready", 32'(host_ready), 1);

    // Fill vs. host conflict, with an ignored restart at sweep cycle 100
    fc0 = fcount;
    fill_start = 1; fill_v = 6'h11;
    host_req = 1; host_x = 2; host_y = 2; host_v = 6'h33;
    #1;
    chk("conflict_host_ready", 32'(host_ready), 0);
    step();
    fill_start = 0;
    cyc = 1;
    chk("fill_first", {tm_w, fill_busy, tm_write_x, tm_write_y, tm_v}, {2'b11, 7'd0, 6'd0, 6'h11});
    chk("fill_host_ready", 32'(host_ready), 0);
    repeat (99) begin step(); cyc++; end
    fill_start = 1; fill_v = 6'h05;
    #1;
    chk("restart_host_ready", 32'(host_ready), 0);
    step(); cyc++;
    fill_start = 0;
    while (!fill_done && cyc < 6000) begin step(); cyc++; end
    chk("fill_done_cycle", cyc, 4801);
    chk("fill_write_count", fcount - fc0, 4800);
    chk("fill_order_errors", ferr, 0);
    chk("fill_end_busy", {fill_busy, tm_w, host_ready}, 3'b001);
    bad = 0;
    for (int i = 0; i < 4800; i++) if (ram[i] !== 6'h11) bad++;
    chk("fill_tiles_not_11", bad, 0);
    step();
    chk("fill_done_pulse", 32'(fill_done), 0);
    chk("pending_host_write", {tm_w, tm_write_x, tm_write_y, tm_v}, {1'b1, 7'd2, 6'd2, 6'h33});
    host_req = 0;
    step();
    rd(7'd0, 6'd0, 6'h11, "fill_rd_0_0");
    rd(7'd79, 6'd59, 6'h11, "fill_rd_79_59");
    rd(7'd2, 6'd2, 6'h33, "fill_rd_2_2");

    // Reset during a sweep
    fill_start = 1; fill_v = 6'h22;
    step();
    fill_start = 0;
    cyc = 1;
    repeat (1999) begin step(); cyc++; end
    chk("midfill_busy", {fill_busy, tm_w}, 2'b11);
    #2 rst = 1'b1;
    #1;
    chk("midfill_rst_busy", {fill_busy, tm_w, fill_done}, 3'b000);
    step();
    rst = 1'b0;
    #1;
    chk("midfill_host_ready", 32'(host_ready), 1);
    rd(7'd0, 6'd0, 6'h22, "midfill_rd_0_0");
    rd(7'd78, 6'd24, 6'h22, "midfill_rd_1998");
    rd(7'd0, 6'd25, 6'h11, "midfill_rd_2000");
    rd(7'd79, 6'd59, 6'h11, "midfill_rd_4799");

    // Out-of-range host write
    host_req = 1; host_x = 80; host_y = 0; host_v = 6'h15;
    #1;
    chk("oob_host_ready", 32'(host_ready), 1);
    step();
    host_req = 0;
`ifdef TILE_MAP_CTRL_BOUNDS_CHECK_EN
    chk("oob_tm_w", 32'(tm_w), 0);
    chk("oob_err_set", 32'(oob_err), 1);
    step();
    chk("oob_err_sticky", 32'(oob_err), 1);
    chk("oob_tm_w_after", 32'(tm_w), 0);
`else
    chk("oob_tm_w", 32'(tm_w), 1);
    chk("oob_tm_write_x", 32'(tm_write_x), 80);
    step();
    chk("oob_tm_w_after", 32'(tm_w), 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/tile_map_ctrl.md
# tile_map_ctrl

Write-port scheduler and read sequencer for the 80×60 tile-index RAM (6-bit entries). It shares the RAM's single write port between a host write channel (valid/ready) and an internal fill engine, which clears or fills the whole map to one value. It also drives the RAM's read port for the display pipeline and aligns the read data with a valid strobe. It sits between the CPU/bus interface, the VGA tile fetcher and the tile-map RAM.

## Interface

- `COLS`, 80, map width in tiles.
- `ROWS`, 60, map height in tiles.
- `TW`, 6, tile index width.
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `host_req`  in  1  host write valid.
- `host_x` / `host_y` / `host_v`  in  7 / 6 / TW  host write column / row / tile value.
- `host_ready`  out  1  host write accepted at an edge where `host_req && host_ready`.
- `fill_start`  in  1  single-cycle request to fill the entire map.
- `fill_v`  in  TW  fill value, sampled with `fill_start`.
- `fill_busy`  out  1  fill engine owns the write port.
- `fill_done`  out  1  one-cycle pulse after the last fill write.
- `disp_req` / `disp_x` / `disp_y`  in  1 / 7 / 6  display read request and address.
- `disp_tile`  out  TW  read data; equals `tm_o`.
- `disp_valid`  out  1  `disp_tile` holds data for the request made one cycle earlier.
- `tm_w` / `tm_write_x` / `tm_write_y` / `tm_v`  out  1 / 7 / 6 / TW  RAM write port; all registered.
- `tm_r` / `tm_x` / `tm_y`  out  1 / 7 / 6  RAM read port; combinational copies of `disp_req` / `disp_x` / `disp_y`.
- `tm_o`  in  TW  RAM registered read data.
- `oob_err`  out  1  sticky out-of-range host write flag; present only with `TILE_MAP_CTRL_BOUNDS_CHECK_EN`.

## Operation

- Two states: IDLE and FILL. Reset enters IDLE.
- `host_ready = (state==IDLE) && !fill_start`. This is combinational.
- **Fill priority.** `fill_start` wins over a simultaneous `host_req`. The host write is not accepted and stays pending.
- **Host write.**
  - An accepted host write registers `tm_w=1` and the coordinates and value for exactly the next cycle.
  - Back-to-back accepts produce back-to-back writes.
  - With no accept (and no fill), `tm_w=0`.
- **Entering FILL.** `fill_start` in IDLE latches `fill_v` and clears counters `cx` (7-bit) and `cy` (6-bit).
- **Fill sweep.**
  - Each FILL cycle issues one write at (`cx`,`cy`) with the latched value.
  - Order is row-major: `cx` increments; at `cx==COLS-1` it wraps to 0 and `cy` increments.
  - After the write at (`COLS-1`,`ROWS-1`) the engine returns to IDLE and pulses `fill_done`.
- **`fill_start` during FILL** is ignored; the latched value is unchanged.
- **`fill_busy`** is 1 in exactly the `COLS*ROWS` write cycles of the sweep.
- **Read path.**
  - The read port is independent of the write port and always available.
  - `disp_valid` is `disp_req` registered.
  - A read that collides with a same-address write in the same cycle returns an unspecified value; the bench must not check it.
- **Reset.** `rst` mid-fill aborts the sweep immediately. Already-written tiles keep their values.
- **Reset values.** `tm_w`, `tm_write_x`, `tm_write_y`, `tm_v`, `fill_busy`, `fill_done`, `disp_valid`, `oob_err` are all 0. `host_ready` is 1 when `fill_start` is 0.

## Timing

- **Host write.** Accept at edge N gives `tm_w=1` during cycle N+1, and the RAM writes at edge N+1. Throughput is 1 write per cycle.
- **Fill.**
  - `fill_start` at edge S gives the first write (0,0) in cycle S+1.
  - The last write (79,59) is in cycle S+4800.
  - `fill_done=1` and `host_ready=1` in cycle S+4801.
- **Read.** `disp_req` at edge N gives `tm_o` updated at edge N. `disp_valid=1` during cycle N+1 with matching `disp_tile`, a latency of 1.
- **Combinational paths.** The only combinational paths are `fill_start` → `host_ready`, `disp_*` → `tm_r/x/y`, and `tm_o` → `disp_tile`.

## Configuration

- **`TILE_MAP_CTRL_BOUNDS_CHECK_EN` defined:**
  - An accepted host write with `host_x>=COLS` or `host_y>=ROWS` is still handshaken, but `tm_w` stays 0 (the write is dropped).
  - `oob_err` sets the next cycle and holds until `rst`.
- **Undefined:**
  - No check is made and coordinates pass through unchanged.
  - `oob_err` does not exist.

## Test plan

- **Reset state.** Assert `rst` asynchronously mid-cycle → all listed outputs are 0 immediately and `host_ready=1` after release.
- **Host writes.** `host_req` with (5,3,v=0x2A) then (79,59,v=0x3F) on consecutive edges → `tm_w=1` for two consecutive cycles with matching addresses and values. A `disp_req` at (5,3) afterwards → `disp_valid` after 1 cycle with `disp_tile=0x2A`.
- **Fill conflict.** `fill_start` (`fill_v=0x11`) and `host_req` in the same cycle → `host_ready=0` and exactly 4800 fill writes in row-major order with `fill_busy=1`. Then `fill_done` pulses and the pending host write issues the cycle after. Reads of (0,0) and (79,59) return 0x11.
- **Ignored restart.** `fill_start` with `fill_v=0x05` at sweep cycle 100 → ignored; all tiles end at 0x11 and the sweep is still 4800 writes.
- **Reset mid-fill.** `rst` at sweep cycle 2000 → `fill_busy` and `tm_w` drop immediately and the state returns to IDLE. Tile (0,0) holds the fill value; a tile at index ≥2000 holds its previous value.
- **Bounds check (macro defined).** Host write to (80,0) → handshake completes, `tm_w` stays 0, `oob_err=1` and sticky.
- **Bounds check (macro undefined).** The same stimulus → `tm_w=1` at `tm_write_x=80`.
